reg_timer_core: RTL and testbench

Register-interface timer peripheral core: a 64-bit prescaled up-counter with a 64-bit compare and one interrupt. It sits directly downstream of the TL-UL register adapter, consuming its `re`/`we`/`addr`/`wdata`/`be` strobes and returning `rdata`/`error` in the same cycle, which the adapter captures on request acceptance.

---
 rtl/reg_timer_pkg.sv | 49 ++++
 rtl/reg_timer_tick.sv | 31 +++
 rtl/reg_timer_core.sv | 114 +++++++++++
 tb/tb_reg_timer_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_timer_pkg.sv
// Shared definitions for the register-interface timer: register offsets,
// the hardware state record and the byte-enable merge helper.
package reg_timer_pkg;

  localparam int unsigned CtrlOffset       = 32'h00;
  localparam int unsigned PrescaleOffset   = 32'h04;
  localparam int unsigned CountLoOffset    = 32'h08;
  localparam int unsigned CountHiOffset    = 32'h0C;
  localparam int unsigned CmpLoOffset      = 32'h10;
  localparam int unsigned CmpHiOffset      = 32'h14;
  localparam int unsigned IntrStateOffset  = 32'h18;
  localparam int unsigned IntrEnableOffset = 32'h1C;
  localparam int unsigned IntrTestOffset   = 32'h20;

  // Software-visible timer state. The prescale field is 32 bits wide so the
  // record does not depend on the core's parameters; the core keeps the bits
  // above its prescaler width at zero.
  typedef struct packed {
    logic        enable;
    logic [31:0] prescale;
    logic [63:0] count;
    logic [63:0] cmp;
    logic        intr_state;
    logic        intr_enable;
  } reg_timer_hw_t;

  // Compare resets to all-ones so nothing fires out of reset.
  localparam reg_timer_hw_t HwReset = '{
    enable:      1'b0,
    prescale:    32'h0,
    count:       64'h0,
    cmp:         '1,
    intr_state:  1'b0,
    intr_enable: 1'b0
  };

  // Replace only the byte lanes selected by be.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_timer_tick.sv
// Prescaler: counts 0..prescale while enabled and pulses tick_o on the
// terminal value, then wraps to 0. Held at 0 while disabled.
module reg_timer_tick #(
  parameter int unsigned PrescaleW = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable,
  input  logic [PrescaleW-1:0] prescale,
  output logic                 tick_o
);

  logic [PrescaleW-1:0] cnt_q, cnt_d;

  // Tick on the terminal value; restart from 0 on tick or when disabled.
  always_comb begin
    tick_o = enable && (cnt_q == prescale);
    cnt_d  = cnt_q + PrescaleW'(1);
    if (!enable || tick_o) cnt_d = '0;
  end

  // Prescaler state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_timer_core.sv
// Timer peripheral core: register decode, 64-bit prescaled up-counter,
// 64-bit compare and a single level interrupt.
module reg_timer_core
  import reg_timer_pkg::*;
#(
  parameter int unsigned RegAw     = 8,
  parameter int unsigned PrescaleW = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             re_i,
  input  logic             we_i,
  input  logic [RegAw-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       be_i,
  output logic [31:0]      rdata_o,
  output logic             error_o,
  output logic             intr_o
);

  localparam logic [RegAw-1:0] AddrCtrl       = RegAw'(CtrlOffset);
  localparam logic [RegAw-1:0] AddrPrescale   = RegAw'(PrescaleOffset);
  localparam logic [RegAw-1:0] AddrCountLo    = RegAw'(CountLoOffset);
  localparam logic [RegAw-1:0] AddrCountHi    = RegAw'(CountHiOffset);
  localparam logic [RegAw-1:0] AddrCmpLo      = RegAw'(CmpLoOffset);
  localparam logic [RegAw-1:0] AddrCmpHi      = RegAw'(CmpHiOffset);
  localparam logic [RegAw-1:0] AddrIntrState  = RegAw'(IntrStateOffset);
  localparam logic [RegAw-1:0] AddrIntrEnable = RegAw'(IntrEnableOffset);
  localparam logic [RegAw-1:0] AddrIntrTest   = RegAw'(IntrTestOffset);

  localparam logic [31:0] PrescaleMask = 32'((64'd1 << PrescaleW) - 64'd1);

  reg_timer_hw_t hw_q, hw_d;
  logic          intr_q;
  logic          tick;
  logic          addr_hit;
  logic          wr_en;
  logic          cmp_hit;
  logic          w1c;
  logic          test_set;
  logic [31:0]   rdata_mux;

  reg_timer_tick #(
    .PrescaleW(PrescaleW)
  ) u_tick (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable   (hw_q.enable),
    .prescale (hw_q.prescale[PrescaleW-1:0]),
    .tick_o   (tick)
  );

  // Address decode and read mux; INTR_TEST is mapped but reads as zero.
  always_comb begin
    addr_hit  = 1'b1;
    rdata_mux = '0;
    case (addr_i)
      AddrCtrl:       rdata_mux = {31'b0, hw_q.enable};
      AddrPrescale:   rdata_mux = hw_q.prescale;
      AddrCountLo:    rdata_mux = hw_q.count[31:0];
      AddrCountHi:    rdata_mux = hw_q.count[63:32];
      AddrCmpLo:      rdata_mux = hw_q.cmp[31:0];
      AddrCmpHi:      rdata_mux = hw_q.cmp[63:32];
      AddrIntrState:  rdata_mux = {31'b0, hw_q.intr_state};
      AddrIntrEnable: rdata_mux = {31'b0, hw_q.intr_enable};
      AddrIntrTest:   rdata_mux = '0;
      default:        addr_hit  = 1'b0;
    endcase
  end

  assign error_o = (re_i | we_i) & ~addr_hit;
  assign rdata_o = (re_i & addr_hit) ? rdata_mux : '0;
  assign wr_en   = we_i & addr_hit;
  assign cmp_hit = hw_q.count >= hw_q.cmp;

  // Next state: tick increment first, then software writes override the
  // written half only, so the other half still takes the carry.
  always_comb begin
    hw_d     = hw_q;
    w1c      = 1'b0;
    test_set = 1'b0;
    if (tick) hw_d.count = hw_q.count + 64'd1;
    if (wr_en) begin
      case (addr_i)
        AddrCtrl:       if (be_i[0]) hw_d.enable = wdata_i[0];
        AddrPrescale:   hw_d.prescale = be_merge(hw_q.prescale, wdata_i, be_i) & PrescaleMask;
        AddrCountLo:    hw_d.count[31:0]  = be_merge(hw_q.count[31:0], wdata_i, be_i);
        AddrCountHi:    hw_d.count[63:32] = be_merge(hw_q.count[63:32], wdata_i, be_i);
        AddrCmpLo:      hw_d.cmp[31:0]    = be_merge(hw_q.cmp[31:0], wdata_i, be_i);
        AddrCmpHi:      hw_d.cmp[63:32]   = be_merge(hw_q.cmp[63:32], wdata_i, be_i);
        AddrIntrState:  w1c = be_i[0] & wdata_i[0];
        AddrIntrEnable: if (be_i[0]) hw_d.intr_enable = wdata_i[0];
        AddrIntrTest:   test_set = be_i[0] & wdata_i[0];
        default:        ;
      endcase
    end
    // Set sources win over a simultaneous clear.
    hw_d.intr_state = cmp_hit | test_set | (hw_q.intr_state & ~w1c);
  end

  // Register state and the registered interrupt output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hw_q   <= HwReset;
      intr_q <= 1'b0;
    end else begin
      hw_q   <= hw_d;
      intr_q <= hw_q.intr_state & hw_q.intr_enable;
    end
  end

  assign intr_o = intr_q;

endmodule

// File: tb/tb_reg_timer_core.sv
// Self-checking bench for reg_timer_core: a vector table for register
// access basics plus hand-written multi-cycle sequences.
module tb_reg_timer_core;

  localparam logic [7:0] AddrCtrl       = 8'h00;
  localparam logic [7:0] AddrPrescale   = 8'h04;
  localparam logic [7:0] AddrCountLo    = 8'h08;
  localparam logic [7:0] AddrCountHi    = 8'h0C;
  localparam logic [7:0] AddrCmpLo      = 8'h10;
  localparam logic [7:0] AddrCmpHi      = 8'h14;
  localparam logic [7:0] AddrIntrState  = 8'h18;
  localparam logic [7:0] AddrIntrEnable = 8'h1C;
  localparam logic [7:0] AddrIntrTest   = 8'h20;

  logic        clk_i;
  logic        rst_ni;
  logic        re_i;
  logic        we_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic [31:0] rdata_o;
  logic        error_o;
  logic        intr_o;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        re;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  reg_timer_core #(
    .RegAw     (8),
    .PrescaleW (12)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .re_i    (re_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .be_i    (be_i),
    .rdata_o (rdata_o),
    .error_o (error_o),
    .intr_o  (intr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, push the expectation, then
  // pop and compare the combinational response 1 ns later.
  task automatic access(input logic re, input logic we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input string name);
    exp_t e;
    @(negedge clk_i);
    re_i    = re;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
    be_i    = be;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    #1;
    e = sb_q.pop_front();
    check({name, " rdata"}, 64'(rdata_o), 64'(e.rdata));
    check({name, " error"}, 64'(error_o), 64'(e.err));
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input string name);
    access(1'b0, 1'b1, addr, data, 4'hF, 32'h0, 1'b0, name);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string name);
    access(1'b1, 1'b0, addr, 32'h0, 4'hF, exp, 1'b0, name);
  endtask

  task automatic idle();
    @(negedge clk_i);
    re_i = 1'b0;
    we_i = 1'b0;
    #1;
  endtask

  task automatic check_intr(input logic exp, input string name);
    check(name, 64'(intr_o), 64'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_ni   = 1'b0;
    re_i     = 1'b0;
    we_i     = 1'b0;
    addr_i   = '0;
    wdata_i  = '0;
    be_i     = '0;

    vecs.push_back('{1'b1, 1'b0, AddrCtrl,       32'h0, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrPrescale,   32'h0, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrCountLo,    32'h0, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrCountHi,    32'h0, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrCmpLo,      32'h0, 4'hF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrCmpHi,      32'h0, 4'hF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrIntrState,  32'h0, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrIntrEnable, 32'h0, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrIntrTest,   32'h0, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'h24,          32'h0, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'h24,          32'h0, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h40,          32'h1, 4'hF, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 1'b0, AddrCtrl,       32'h0, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, AddrCmpLo,      32'hAABBCCDD, 4'b0101, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrCmpLo,      32'h0, 4'hF, 32'hFFBBFFDD, 1'b0});
    vecs.push_back('{1'b0, 1'b1, AddrCmpLo,      32'h11223344, 4'b1010, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrCmpLo,      32'h0, 4'hF, 32'h11BB33DD, 1'b0});
    vecs.push_back('{1'b0, 1'b1, AddrCmpLo,      32'hFFFFFFFF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrCmpLo,      32'h0, 4'hF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, AddrPrescale,   32'hFFFFFFFF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, AddrPrescale,   32'h0, 4'hF, 32'h00000FFF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, AddrPrescale,   32'h0, 4'hF, 32'h0,        1'b0});

    repeat (3) @(negedge clk_i);
    #1;
    check_intr(1'b0, "intr in reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_intr(1'b0, "intr after reset");

    foreach (vecs[i]) begin
      access(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Prescale 3: count advances once every 4 cycles after enable.
    wr(AddrPrescale, 32'd3, "wr prescale");
    wr(AddrCtrl, 32'd1, "wr enable");
    for (int k = 1; k <= 12; k++) begin
      rd(AddrCountLo, 32'((k - 1) / 4), $sformatf("presc count k%0d", k));
    end
    wr(AddrCtrl, 32'd0, "wr disable");
    rd(AddrCountLo, 32'd3, "frozen count a");
    repeat (3) idle();
    rd(AddrCountLo, 32'd3, "frozen count b");
    rd(AddrCountHi, 32'd0, "frozen count hi");

    // Carry from low into high half.
    wr(AddrPrescale, 32'd0, "wr prescale 0");
    wr(AddrCountLo, 32'hFFFFFFFF, "wr lo carry");
    wr(AddrCountHi, 32'h0, "wr hi carry");
    wr(AddrCtrl, 32'd1, "carry enable");
    wr(AddrCtrl, 32'd0, "carry disable");
    rd(AddrCountHi, 32'd1, "carry hi");
    rd(AddrCountLo, 32'd0, "carry lo");

    // Software write to COUNT_LO beats the tick; high half keeps counting.
    wr(AddrCtrl, 32'd1, "ww enable");
    idle();
    wr(AddrCountLo, 32'h10, "ww write lo");
    wr(AddrCtrl, 32'd0, "ww disable");
    rd(AddrCountLo, 32'h11, "ww lo");
    rd(AddrCountHi, 32'h1, "ww hi");

    // Full 64-bit wrap; the all-ones count meets the all-ones compare.
    wr(AddrCountLo, 32'hFFFFFFFF, "wrap wr lo");
    wr(AddrCountHi, 32'hFFFFFFFF, "wrap wr hi");
    wr(AddrCtrl, 32'd1, "wrap enable");
    wr(AddrCtrl, 32'd0, "wrap disable");
    rd(AddrCountLo, 32'd0, "wrap lo");
    rd(AddrCountHi, 32'd0, "wrap hi");
    rd(AddrIntrState, 32'd1, "wrap intr state");
    wr(AddrIntrState, 32'd1, "wrap w1c");
    rd(AddrIntrState, 32'd0, "wrap intr cleared");
    check_intr(1'b0, "wrap intr masked");

    // Compare at 5 with the interrupt enabled.
    wr(AddrCountLo, 32'd0, "cmp wr count lo");
    wr(AddrCountHi, 32'd0, "cmp wr count hi");
    wr(AddrCmpLo, 32'd5, "cmp wr lo");
    wr(AddrCmpHi, 32'd0, "cmp wr hi");
    wr(AddrIntrEnable, 32'd1, "cmp intr en");
    wr(AddrCtrl, 32'd1, "cmp enable");
    for (int k = 1; k <= 9; k++) begin
      rd(AddrIntrState, 32'(k >= 7), $sformatf("cmp state k%0d", k));
      check_intr(k >= 8, $sformatf("cmp intr k%0d", k));
    end
    wr(AddrIntrState, 32'd1, "cmp w1c held");
    rd(AddrIntrState, 32'd1, "cmp state held");
    check_intr(1'b1, "cmp intr held");
    wr(AddrCmpLo, 32'hFFFFFFFF, "cmp reset lo");
    wr(AddrCmpHi, 32'hFFFFFFFF, "cmp reset hi");
    wr(AddrCtrl, 32'd0, "cmp disable");
    wr(AddrIntrState, 32'd1, "cmp w1c");
    rd(AddrIntrState, 32'd0, "cmp state cleared");
    check_intr(1'b1, "cmp intr lag");
    idle();
    check_intr(1'b0, "cmp intr fell");

    // INTR_TEST with the interrupt masked, then unmasked.
    wr(AddrIntrEnable, 32'd0, "test intr dis");
    wr(AddrIntrTest, 32'd1, "test write");
    rd(AddrIntrState, 32'd1, "test state");
    check_intr(1'b0, "test intr masked a");
    rd(AddrIntrTest, 32'd0, "test readback");
    check_intr(1'b0, "test intr masked b");
    wr(AddrIntrEnable, 32'd1, "test intr en");
    idle();
    check_intr(1'b0, "test intr lag");
    idle();
    check_intr(1'b1, "test intr on");

    // Asynchronous reset mid-cycle clears state and drops intr_o at once.
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_intr(1'b0, "async reset intr");
    @(negedge clk_i);
    rst_ni = 1'b1;
    rd(AddrCountLo, 32'd0, "post reset count lo");
    rd(AddrCmpLo, 32'hFFFFFFFF, "post reset cmp lo");
    rd(AddrIntrState, 32'd0, "post reset state");
    rd(AddrIntrEnable, 32'd0, "post reset intr en");
    idle();
    check_intr(1'b0, "post reset intr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
